// File: rtl/universal_reg.sv
// rtl/universal_reg.sv - universal shift/load register with preset, status flags and change pulse (optional ring mode: UNIVERSAL_REG_RING_EN)
module universal_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             preset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             sout_r,
    output logic             sout_l,
    output logic             zero,
    output logic             upd
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] reg_d;
    logic             upd_q;
    logic             upd_d;

    logic             in_r;
    logic             in_l;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] shl_val;

`ifdef UNIVERSAL_REG_RING_EN
    // Ring build: the bit falling off one end re-enters at the other; serial inputs are not used.
    logic unused_sin;
    assign unused_sin = sin_r ^ sin_l;
    assign in_r = reg_q[0];
    assign in_l = reg_q[WIDTH-1];
`else
    assign in_r = sin_r;
    assign in_l = sin_l;
`endif

    // A one-bit register has nothing to shift along; the incoming bit simply replaces it.
    generate
        if (WIDTH == 1) begin : g_narrow
            assign shr_val = in_r;
            assign shl_val = in_l;
        end else begin : g_wide
            assign shr_val = {in_r, reg_q[WIDTH-1:1]};
            assign shl_val = {reg_q[WIDTH-2:0], in_l};
        end
    endgenerate

    // Next-state selection: preset beats mode operations; clear is applied in the register process.
    always_comb begin
        reg_d = reg_q;
        if (preset) begin
            reg_d = '1;
        end else if (en) begin
            case (mode)
                MODE_HOLD: reg_d = reg_q;
                MODE_SHR:  reg_d = shr_val;
                MODE_SHL:  reg_d = shl_val;
                MODE_LOAD: reg_d = d;
                default:   reg_d = reg_q;
            endcase
        end
        upd_d = (reg_d != reg_q);
    end

    // State register with synchronous clear overriding every other operation.
    always_ff @(posedge clk) begin
        if (clear) begin
            reg_q <= RESET_VALUE;
            upd_q <= 1'b0;
        end else begin
            reg_q <= reg_d;
            upd_q <= upd_d;
        end
    end

    assign q      = reg_q;
    assign qn     = ~reg_q;
    assign sout_r = reg_q[0];
    assign sout_l = reg_q[WIDTH-1];
    assign zero   = (reg_q == '0);
    assign upd    = upd_q;

endmodule

// File: tb/tb_universal_reg.sv
// tb/tb_universal_reg.sv - directed self-checking bench for universal_reg (WIDTH=8, RESET_VALUE=0)
module tb_universal_reg;

    logic       clk = 1'b0;
    logic       clear, preset, en, sin_r, sin_l;
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] q, qn;
    logic       sout_r, sout_l, zero, upd;

    int n_cmp = 0;
    int n_bad = 0;

    universal_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
        .clk    (clk),
        .clear  (clear),
        .preset (preset),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q      (q),
        .qn     (qn),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .zero   (zero),
        .upd    (upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, wait for one rising edge, then settle before sampling.
    task automatic step(input logic c, input logic p, input logic e, input logic [1:0] m,
                        input logic [7:0] dv, input logic sr, input logic sl);
        clear = c; preset = p; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_shr1, exp_shr4, exp_after_clr1, exp_after_clr2;
    logic       exp_upd_after_clr;

    initial begin
`ifdef UNIVERSAL_REG_RING_EN
        exp_shr1          = 8'hC0;
        exp_shr4          = 8'h69;
        exp_after_clr1    = 8'h00;
        exp_after_clr2    = 8'h00;
        exp_upd_after_clr = 1'b0;
`else
        exp_shr1          = 8'h40;
        exp_shr4          = 8'hF9;
        exp_after_clr1    = 8'h80;
        exp_after_clr2    = 8'h40;
        exp_upd_after_clr = 1'b1;
`endif
        clear = 1'b0; preset = 1'b0; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
        @(negedge clk);

        // Clear overrides preset and load
        step(1'b1, 1'b1, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
        check("rst_q", q, 8'h00);
        check("rst_qn", qn, 8'hFF);
        check("rst_zero", zero, 1'b1);
        check("rst_upd", upd, 1'b0);
        check("rst_sout_r", sout_r, 1'b0);
        check("rst_sout_l", sout_l, 1'b0);

        // Load then right shift
        step(1'b0, 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
        check("load81_q", q, 8'h81);
        check("load81_upd", upd, 1'b1);
        check("load81_sout_r", sout_r, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        check("shr_q", q, exp_shr1);
        check("shr_sout_r", sout_r, 1'b0);
        check("shr_upd", upd, 1'b1);

        // Reload then left shift with sin_l=1
        step(1'b0, 1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
        check("reload81_q", q, 8'h81);
        step(1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
        check("shl_q", q, 8'h03);
        check("shl_sout_l", sout_l, 1'b0);
        check("shl_upd", upd, 1'b1);

        // Preset with en=0, then repeated preset
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("preset_q", q, 8'hFF);
        check("preset_zero", zero, 1'b0);
        check("preset_qn", qn, 8'h00);
        check("preset_upd", upd, 1'b1);
        step(1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        check("preset2_q", q, 8'hFF);
        check("preset2_upd", upd, 1'b0);

        // Disabled load for three edges
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'b11, 8'h3C, 1'b1, 1'b1);
            check($sformatf("dis%0d_q", i), q, 8'hFF);
            check($sformatf("dis%0d_upd", i), upd, 1'b0);
        end

        // Hold mode with en=1
        step(1'b0, 1'b0, 1'b1, 2'b00, 8'h12, 1'b1, 1'b1);
        check("hold_q", q, 8'hFF);
        check("hold_upd", upd, 1'b0);

        // Four right shifts with sin_r=1 from 8'h96, then clear mid-sequence
        step(1'b0, 1'b0, 1'b1, 2'b11, 8'h96, 1'b0, 1'b0);
        check("load96_q", q, 8'h96);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        check("shr4_q", q, exp_shr4);
        step(1'b1, 1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        check("midclr_q", q, 8'h00);
        check("midclr_upd", upd, 1'b0);
        check("midclr_zero", zero, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        check("resume1_q", q, exp_after_clr1);
        check("resume1_upd", upd, exp_upd_after_clr);
        step(1'b0, 1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        check("resume2_q", q, exp_after_clr2);

        // Loading a value equal to q gives no update pulse
        step(1'b0, 1'b0, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0);
        check("load5a_q", q, 8'h5A);
        check("load5a_upd", upd, 1'b1);
        step(1'b0, 1'b0, 1'b1, 2'b11, 8'h5A, 1'b0, 1'b0);
        check("reload5a_upd", upd, 1'b0);
        check("reload5a_sout_l", sout_l, 1'b0);

        // Left shift sin_l=0 of 8'h5A -> 8'hB4, preset wins over load
        step(1'b0, 1'b0, 1'b1, 2'b10, 8'h00, 1'b1, 1'b0);
`ifdef UNIVERSAL_REG_RING_EN
        check("shl5a_q", q, 8'hB4);
`else
        check("shl5a_q", q, 8'hB4);
`endif
        check("shl5a_sout_l", sout_l, 1'b1);
        step(1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
        check("preset_over_load_q", q, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/universal_reg.md
UNIVERSAL_REG -- requirements
Module: universal_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal range is 1 to 64.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0 (WIDTH bits), giving the value loaded by clear.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port preset, input, 1 bit: synchronous active-high set-all-ones.
REQ-006 The block SHALL have port en, input, 1 bit: enables mode operations.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 The block SHALL have port d, input, WIDTH bits: parallel load data.
REQ-009 The block SHALL have port sin_r, input, 1 bit: serial input entering q[WIDTH-1] on a right shift.
REQ-010 The block SHALL have port sin_l, input, 1 bit: serial input entering q[0] on a left shift.
REQ-011 The block SHALL have port q, output, WIDTH bits: register contents.
REQ-012 The block SHALL have port qn, output, WIDTH bits: bitwise complement of q.
REQ-013 The block SHALL have port sout_r, output, 1 bit: equal to q[0].
REQ-014 The block SHALL have port sout_l, output, 1 bit: equal to q[WIDTH-1].
REQ-015 The block SHALL have port zero, output, 1 bit: high when q is all zeros.
REQ-016 The block SHALL have port upd, output, 1 bit: registered pulse flagging that q changed on the previous edge.

Function
REQ-017 Per rising clk edge, the block SHALL apply this priority: clear, then preset, then en/mode, then hold.
REQ-018 With clear=0, preset=1, the block SHALL load q with all ones, regardless of en and mode.
REQ-019 With clear=0, preset=0, en=1, mode=01, the block SHALL load q with {sin_r, q[WIDTH-1:1]}.
REQ-020 With clear=0, preset=0, en=1, mode=10, the block SHALL load q with {q[WIDTH-2:0], sin_l}.
REQ-021 With clear=0, preset=0, en=1, mode=11, the block SHALL load q with d.
REQ-022 With en=0 or mode=00 (and clear=0, preset=0), the block SHALL hold q.
REQ-023 When WIDTH=1, the block SHALL load q with sin_r on a right shift and with sin_l on a left shift.
REQ-024 The block SHALL drive qn, sout_r, sout_l and zero combinationally from q, with zero latency and no extra state.
REQ-025 On each edge without clear, the block SHALL register upd as 1 if the new q differs from the old q, else 0; upd is therefore a single-cycle pulse per change.
REQ-026 The block SHALL leave upd at 0 for a load or shift that produces an unchanged value (e.g. loading d equal to q).
REQ-027 The block SHALL ignore unknown or changed inputs between edges; only values sampled at the rising edge of clk take effect.

Reset
REQ-028 When clear=1 at a rising clk edge, the block SHALL set q to RESET_VALUE and upd to 0, overriding preset, en, mode and any operation in progress.
REQ-029 After reset, the block SHALL present qn=~RESET_VALUE, sout_r=RESET_VALUE[0], sout_l=RESET_VALUE[WIDTH-1], and zero=1 if RESET_VALUE is all zeros.
REQ-030 The block SHALL have no asynchronous reset path; before the first clear edge, q is undefined.

Configuration
REQ-031 With macro UNIVERSAL_REG_RING_EN defined, the block SHALL recirculate bits on shifts: right shift loads {q[0], q[WIDTH-1:1]}, left shift loads {q[WIDTH-2:0], q[WIDTH-1]}, and sin_r and sin_l are ignored.
REQ-032 Without UNIVERSAL_REG_RING_EN, the block SHALL shift exactly as REQ-019 and REQ-020 specify; all other behaviour is identical in both builds.

Verification (WIDTH=8, RESET_VALUE=0)
REQ-033 The bench SHALL check: clear=1, preset=1, mode=11, d=8'hA5 for one edge -> q=8'h00, qn=8'hFF, zero=1, upd=0.
REQ-034 The bench SHALL check: load d=8'h81 (en=1, mode=11), then mode=01 with sin_r=0 -> q=8'h81 then 8'h40; sout_r=0; upd=1 on both following cycles. With ring build: second value 8'hC0.
REQ-035 The bench SHALL check: q=8'h81, mode=10, sin_l=1 -> q=8'h03; sout_l=0. With ring build: q=8'h03.
REQ-036 The bench SHALL check: preset=1 with en=0 -> q=8'hFF, zero=0; repeated preset -> upd=0 on the second cycle.
REQ-037 The bench SHALL check: en=0, mode=11, d=8'h3C for 3 edges -> q unchanged, upd=0 for all 3 cycles.
REQ-038 The bench SHALL check: clear=1 asserted mid-sequence after 4 right shifts -> q=8'h00 on the next edge, and shifting resumes from 8'h00 when clear=0.
